// File: rtl/bib3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bib3_pkg
//  Description : Shared types, field positions and the combinational bib3
//                operation used by the bib3_hakem arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bib3_pkg;

    localparam int BUYRUK_W = 9;
    localparam int SONUC_W  = 4;

    // buyruk = {opcode[8:6], sayi1[5:3], sayi2[2:0]}
    localparam int OPCODE_MSB = 8;
    localparam int OPCODE_LSB = 6;
    localparam int SAYI1_MSB  = 5;
    localparam int SAYI1_LSB  = 3;
    localparam int SAYI2_MSB  = 2;
    localparam int SAYI2_LSB  = 0;

    localparam logic [2:0] OP_TOPLA = 3'b000;  // sayi1 + sayi2
    localparam logic [2:0] OP_CIKAR = 3'b001;  // sayi1 - sayi2 (4-bit wrap)
    localparam logic [2:0] OP_VE    = 3'b010;  // sayi1 & sayi2
    localparam logic [2:0] OP_VEYA  = 3'b011;  // sayi1 | sayi2
    localparam logic [2:0] OP_XOR   = 3'b100;  // sayi1 ^ sayi2
    localparam logic [2:0] OP_DEGIL = 3'b101;  // ~sayi1, zero-extended
    localparam logic [2:0] OP_KAYDIR = 3'b110; // sayi1 << 1
    localparam logic [2:0] OP_BUYUK = 3'b111;  // 1 if sayi1 > sayi2 else 0

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISLEM = 2'd1,
        CEVAP = 2'd2
    } durum_t;

    // Combinational bib3 unit: one instruction in, one 4-bit result out.
    function automatic logic [SONUC_W-1:0] bib3(input logic [BUYRUK_W-1:0] b);
        logic [2:0]         op;
        logic [2:0]         s1;
        logic [2:0]         s2;
        logic [SONUC_W-1:0] a4;
        logic [SONUC_W-1:0] b4;
        logic [SONUC_W-1:0] r;
        op = b[OPCODE_MSB:OPCODE_LSB];
        s1 = b[SAYI1_MSB:SAYI1_LSB];
        s2 = b[SAYI2_MSB:SAYI2_LSB];
        a4 = {1'b0, s1};
        b4 = {1'b0, s2};
        case (op)
            OP_TOPLA:  r = a4 + b4;
            OP_CIKAR:  r = a4 - b4;
            OP_VE:     r = a4 & b4;
            OP_VEYA:   r = a4 | b4;
            OP_XOR:    r = a4 ^ b4;
            OP_DEGIL:  r = {1'b0, ~s1};
            OP_KAYDIR: r = {s1, 1'b0};
            default:   r = (s1 > s2) ? 4'd1 : 4'd0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bib3_hakem_rr_sec.sv
`default_nettype none
// ============================================================================
//  Module      : bib3_rr_sec
//  Description : Combinational two-way round-robin picker. A lone request
//                wins outright; on contention the requester not served last
//                (~son) wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module bib3_rr_sec (
    input  logic [1:0] valid,
    input  logic       son,
    output logic       grant,
    output logic       any
);

    // Pick the winner index from the request vector and last-served pointer.
    always_comb begin
        any   = |valid;
        grant = 1'b0;
        case (valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~son;
            default: grant = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bib3_hakem.sv
`default_nettype none
// ============================================================================
//  Module      : bib3_hakem
//  Description : Round-robin arbiter sharing one bib3 unit between two
//                requesters. Capture -> compute -> respond, one op every
//                three cycles, all outputs registered.
//                Optional build macro: BIB3_HAKEM_STATS_EN adds saturating
//                per-requester completion counters sayac0/sayac1.
//  Revision    : 1.0 - initial release
// ============================================================================
module bib3_hakem
    import bib3_pkg::*;
#(
    parameter int unsigned ILK_ONCELIK = 0,
    parameter int unsigned SAYAC_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          istek_gecerli,
    input  logic [BUYRUK_W-1:0] buyruk0,
    input  logic [BUYRUK_W-1:0] buyruk1,
    output logic [1:0]          istek_ack,
    output logic [1:0]          sonuc_gecerli,
    output logic [SONUC_W-1:0]  sonuc
`ifdef BIB3_HAKEM_STATS_EN
    ,
    output logic [SAYAC_W-1:0]  sayac0,
    output logic [SAYAC_W-1:0]  sayac1
`endif
);

    durum_t                r_state;
    logic [1:0]            r_ack;
    logic [1:0]            r_sv;
    logic [SONUC_W-1:0]    r_sonuc;
    logic [BUYRUK_W-1:0]   r_buyruk;
    logic                  r_grant;
    logic                  r_son;

    logic                  w_grant;
    logic                  w_any;
    logic [SONUC_W-1:0]    w_sonuc;

    bib3_rr_sec u_sec (
        .valid (istek_gecerli),
        .son   (r_son),
        .grant (w_grant),
        .any   (w_any)
    );

    // The single shared bib3 unit, fed only from the captured instruction.
    assign w_sonuc = bib3(r_buyruk);

    // Arbiter FSM: capture in BOSTA, compute in ISLEM, pulse result in CEVAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= BOSTA;
            r_ack    <= 2'b00;
            r_sv     <= 2'b00;
            r_sonuc  <= '0;
            r_buyruk <= '0;
            r_grant  <= 1'b0;
            r_son    <= (ILK_ONCELIK == 0);
        end else begin
            case (r_state)
                BOSTA: begin
                    if (w_any) begin
                        r_buyruk <= w_grant ? buyruk1 : buyruk0;
                        r_grant  <= w_grant;
                        r_ack    <= w_grant ? 2'b10 : 2'b01;
                        r_state  <= ISLEM;
                    end
                end
                ISLEM: begin
                    r_sonuc <= w_sonuc;
                    r_sv    <= r_grant ? 2'b10 : 2'b01;
                    r_ack   <= 2'b00;
                    r_state <= CEVAP;
                end
                CEVAP: begin
                    r_sv    <= 2'b00;
                    r_son   <= r_grant;
                    r_state <= BOSTA;
                end
                default: begin
                    r_ack   <= 2'b00;
                    r_sv    <= 2'b00;
                    r_state <= BOSTA;
                end
            endcase
        end
    end

    assign istek_ack     = r_ack;
    assign sonuc_gecerli = r_sv;
    assign sonuc         = r_sonuc;

`ifdef BIB3_HAKEM_STATS_EN
    logic [SAYAC_W-1:0] r_sayac0;
    logic [SAYAC_W-1:0] r_sayac1;

    // Count completed ops per requester at the response edge, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sayac0 <= '0;
            r_sayac1 <= '0;
        end else if (r_state == CEVAP) begin
            if (!r_grant && (r_sayac0 != {SAYAC_W{1'b1}})) begin
                r_sayac0 <= r_sayac0 + 1'b1;
            end
            if (r_grant && (r_sayac1 != {SAYAC_W{1'b1}})) begin
                r_sayac1 <= r_sayac1 + 1'b1;
            end
        end
    end

    assign sayac0 = r_sayac0;
    assign sayac1 = r_sayac1;
`else
    // Counter width is only meaningful in the statistics build.
    logic w_unused_sayac_w;
    assign w_unused_sayac_w = (SAYAC_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_bib3_hakem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bib3_hakem
//  Description : Self-checking bench for bib3_hakem: table of single-requester
//                ops with hand-computed results, plus contention, alternation,
//                mid-op reset and idle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bib3_hakem;

    logic       clk;
    logic       rst;
    logic [1:0] istek_gecerli;
    logic [8:0] buyruk0;
    logic [8:0] buyruk1;
    logic [1:0] istek_ack;
    logic [1:0] sonuc_gecerli;
    logic [3:0] sonuc;
`ifdef BIB3_HAKEM_STATS_EN
    logic [7:0] sayac0;
    logic [7:0] sayac1;
`endif

    int checks = 0;
    int errors = 0;

    bib3_hakem #(.ILK_ONCELIK(0), .SAYAC_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .istek_gecerli (istek_gecerli),
        .buyruk0       (buyruk0),
        .buyruk1       (buyruk1),
        .istek_ack     (istek_ack),
        .sonuc_gecerli (sonuc_gecerli),
        .sonuc         (sonuc)
`ifdef BIB3_HAKEM_STATS_EN
        ,
        .sayac0        (sayac0),
        .sayac1        (sayac1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [8:0] buyruk;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        istek_gecerli = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One complete op on a single requester, checking ack, result pulse and hold.
    task automatic run_op(input logic req, input logic [8:0] b, input logic [3:0] exp);
        logic [1:0] oh;
        int n;
        oh = req ? 2'b10 : 2'b01;
        if (req) buyruk1 = b; else buyruk0 = b;
        istek_gecerli = oh;
        tick();
        n = 0;
        while (istek_ack == 2'b00 && n < 5) begin
            tick();
            n++;
        end
        chk("op_ack", {30'd0, istek_ack}, {30'd0, oh});
        chk("op_sv_during_ack", {30'd0, sonuc_gecerli}, 32'd0);
        istek_gecerli = 2'b00;
        tick();
        chk("op_ack_drop", {30'd0, istek_ack}, 32'd0);
        chk("op_sv", {30'd0, sonuc_gecerli}, {30'd0, oh});
        chk("op_sonuc", {28'd0, sonuc}, {28'd0, exp});
        tick();
        chk("op_sv_drop", {30'd0, sonuc_gecerli}, 32'd0);
        chk("op_sonuc_hold", {28'd0, sonuc}, {28'd0, exp});
    endtask

    initial begin
        int         gcount;
        logic       exp_g;
        logic [3:0] held;

        vecs[0] = '{1'b0, 9'b000_011_010, 4'd5};
        vecs[1] = '{1'b1, 9'b001_010_101, 4'd13};
        vecs[2] = '{1'b0, 9'b010_110_011, 4'd2};
        vecs[3] = '{1'b1, 9'b011_100_001, 4'd5};
        vecs[4] = '{1'b0, 9'b100_111_101, 4'd2};
        vecs[5] = '{1'b1, 9'b101_010_000, 4'd5};
        vecs[6] = '{1'b0, 9'b110_111_000, 4'd14};
        vecs[7] = '{1'b1, 9'b111_101_011, 4'd1};
        vecs[8] = '{1'b0, 9'b111_001_110, 4'd0};
        vecs[9] = '{1'b1, 9'b000_111_111, 4'd14};

        rst = 1'b1;
        istek_gecerli = 2'b00;
        buyruk0 = '0;
        buyruk1 = '0;
        do_reset();

        chk("rst_ack", {30'd0, istek_ack}, 32'd0);
        chk("rst_sv", {30'd0, sonuc_gecerli}, 32'd0);
        chk("rst_sonuc", {28'd0, sonuc}, 32'd0);
`ifdef BIB3_HAKEM_STATS_EN
        chk("rst_sayac0", {24'd0, sayac0}, 32'd0);
        chk("rst_sayac1", {24'd0, sayac1}, 32'd0);
`endif

        // Table of single-requester operations
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].req, vecs[i].buyruk, vecs[i].exp);
        end

        // Contention from reset: req0 first, req1 three cycles later
        do_reset();
        buyruk0 = 9'b000_001_001;
        buyruk1 = 9'b000_010_010;
        istek_gecerli = 2'b11;
        tick();
        chk("cont_ack0", {30'd0, istek_ack}, 32'd1);
        istek_gecerli = 2'b10;
        tick();
        chk("cont_sv0", {30'd0, sonuc_gecerli}, 32'd1);
        chk("cont_sonuc0", {28'd0, sonuc}, 32'd2);
        chk("cont_ack_gap", {30'd0, istek_ack}, 32'd0);
        tick();
        chk("cont_sv_gap", {30'd0, sonuc_gecerli}, 32'd0);
        chk("cont_ack_gap2", {30'd0, istek_ack}, 32'd0);
        tick();
        chk("cont_ack1", {30'd0, istek_ack}, 32'd2);
        istek_gecerli = 2'b00;
        tick();
        chk("cont_sv1", {30'd0, sonuc_gecerli}, 32'd2);
        chk("cont_sonuc1", {28'd0, sonuc}, 32'd4);
        tick();

        // Both valid continuously for 12 cycles: grants alternate 0,1,0,1
        do_reset();
        istek_gecerli = 2'b11;
        gcount = 0;
        exp_g = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("alt_exclusive", {31'd0, (istek_ack != 2'b00) && (sonuc_gecerli != 2'b00)}, 32'd0);
            if (istek_ack != 2'b00) begin
                chk("alt_grant", {30'd0, istek_ack}, exp_g ? 32'd2 : 32'd1);
                exp_g = ~exp_g;
                gcount++;
            end
        end
        chk("alt_count", gcount, 32'd4);

        // Reset during ISLEM drops the op
        istek_gecerli = 2'b00;
        tick();
        tick();
        tick();
        buyruk0 = 9'b000_011_011;
        istek_gecerli = 2'b01;
        tick();
        chk("mid_ack", {30'd0, istek_ack}, 32'd1);
        rst = 1'b1;
        istek_gecerli = 2'b00;
        tick();
        chk("mid_rst_ack", {30'd0, istek_ack}, 32'd0);
        chk("mid_rst_sv", {30'd0, sonuc_gecerli}, 32'd0);
        chk("mid_rst_sonuc", {28'd0, sonuc}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_no_sv_a", {30'd0, sonuc_gecerli}, 32'd0);
        tick();
        chk("mid_no_sv_b", {30'd0, sonuc_gecerli}, 32'd0);
        run_op(1'b1, 9'b011_001_110, 4'd7);

        // Idle for 20 cycles: no pulses, sonuc holds
        istek_gecerli = 2'b00;
        held = 4'd7;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_ack", {30'd0, istek_ack}, 32'd0);
            chk("idle_sv", {30'd0, sonuc_gecerli}, 32'd0);
            chk("idle_sonuc", {28'd0, sonuc}, {28'd0, held});
        end

`ifdef BIB3_HAKEM_STATS_EN
        // 300 ops on req0 saturate sayac0; reset clears both counters
        do_reset();
        for (int i = 0; i < 300; i++) begin
            run_op(1'b0, 9'b000_001_010, 4'd3);
        end
        chk("stats_sayac0", {24'd0, sayac0}, 32'hFF);
        chk("stats_sayac1", {24'd0, sayac1}, 32'd0);
        do_reset();
        chk("stats_clr0", {24'd0, sayac0}, 32'd0);
        chk("stats_clr1", {24'd0, sayac1}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
